// File: rtl/soc_mmio_bridge_if.sv
// soc_mmio_bridge_if
// CPU memory-port bundle between the core and soc_mmio_bridge.
//   cpu_valid    request, held high by the CPU until cpu_done
//   cpu_addr     byte address (bits [1:0] ignored, word access)
//   cpu_wdata    write data
//   cpu_wstrobe  1 = write, 0 = read
//   cpu_rdata    read data, valid only while cpu_done = 1
//   cpu_done     one-cycle completion pulse
// Modports: master = CPU side, slave = bridge side.
interface soc_mmio_bridge_if;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_wstrobe;
  logic [31:0] cpu_rdata;
  logic        cpu_done;

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrobe,
    input  cpu_rdata, cpu_done
  );

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrobe,
    output cpu_rdata, cpu_done
  );
endinterface

// File: rtl/soc_mmio_bridge.sv
// soc_mmio_bridge
// Address decoder and MMIO block between the CPU memory port and the word RAM.
// Routes each access to RAM, to a 16-byte I/O register window (LED bytes,
// key levels, sticky press flags, free-running cycle counter) or to an error
// response, and produces the CPU completion pulse for every access.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   cpu                soc_mmio_bridge_if.slave (CPU request/response)
//   ram_addr/ram_wdata pass-through of cpu_addr/cpu_wdata
//   ram_wstrobe        RAM write enable, high only while waiting on a RAM write
//   ram_rdata/ram_done RAM read data and completion
//   key_state          debounced key levels
//   key_press          one-cycle key press pulses
//   leds1..leds4       LED holding bytes
//   bus_err            sticky error flag, cleared only by reset
//
// Optional feature: define SOC_MMIO_TIMEOUT_EN to force completion of a RAM
// access (rdata 0, bus_err set) after RAM_TIMEOUT cycles without ram_done.
module soc_mmio_bridge #(
  parameter int unsigned RAM_WORDS   = 1024,
  parameter logic [31:0] IO_BASE     = 32'h8000_0000,
  parameter int unsigned RAM_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  soc_mmio_bridge_if.slave        cpu,
  output logic [31:0]             ram_addr,
  output logic [31:0]             ram_wdata,
  output logic                    ram_wstrobe,
  input  logic [31:0]             ram_rdata,
  input  logic                    ram_done,
  input  logic [3:0]              key_state,
  input  logic [3:0]              key_press,
  output logic [7:0]              leds1,
  output logic [7:0]              leds2,
  output logic [7:0]              leds3,
  output logic [7:0]              leds4,
  output logic                    bus_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    IO_RESP  = 2'd2,
    ERR_RESP = 2'd3
  } state_t;

  localparam logic [1:0] REG_LEDS   = 2'd0;
  localparam logic [1:0] REG_KEYS   = 2'd1;
  localparam logic [1:0] REG_PRESS  = 2'd2;
  localparam logic [1:0] REG_CYCLES = 2'd3;

  // 33 bits so a RAM that fills the whole 4 GiB space still compares correctly.
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  state_t      state;
  state_t      state_next;
  logic        hit_ram;
  logic        hit_io;
  logic        decode_fire;
  logic [1:0]  reg_sel;
  logic        wr_q;
  logic [31:0] io_rdata;
  logic [31:0] read_mux;
  logic [3:0]  press_flags;
  logic [3:0]  press_clear;
  logic [31:0] cycle_count;
  logic        done_c;
  logic [31:0] rdata_c;
  logic        ram_we_c;
  logic        timeout_hit;

  assign hit_ram     = ({1'b0, cpu.cpu_addr} < RAM_BYTES);
  assign hit_io      = (cpu.cpu_addr[31:4] == IO_BASE[31:4]);
  assign decode_fire = (state == IDLE) && cpu.cpu_valid;

  assign ram_addr  = cpu.cpu_addr;
  assign ram_wdata = cpu.cpu_wdata;

`ifdef SOC_MMIO_TIMEOUT_EN
  localparam int TW = ($clog2(RAM_TIMEOUT + 1) > 8) ? $clog2(RAM_TIMEOUT + 1) : 8;

  logic [TW-1:0] wait_cnt;

  // wait_cnt is 0 in the first RAM_WAIT cycle, so the limit is hit in cycle RAM_TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst_n || state != RAM_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == RAM_WAIT) && !ram_done &&
                       (wait_cnt == TW'(RAM_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done_c     = 1'b0;
    rdata_c    = '0;
    ram_we_c   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu.cpu_valid) begin
          if (hit_ram) begin
            state_next = RAM_WAIT;
          end else if (hit_io) begin
            state_next = IO_RESP;
          end else begin
            state_next = ERR_RESP;
          end
        end
      end
      RAM_WAIT: begin
        ram_we_c = wr_q && !timeout_hit;
        rdata_c  = timeout_hit ? 32'h0 : ram_rdata;
        if (ram_done || timeout_hit) begin
          done_c     = 1'b1;
          state_next = IDLE;
        end
      end
      IO_RESP: begin
        done_c     = 1'b1;
        rdata_c    = io_rdata;
        state_next = IDLE;
      end
      ERR_RESP: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with rst_n makes a reset abandon the access in the same cycle,
  // even if the RAM completes while reset is asserted.
  assign cpu.cpu_done  = done_c & rst_n;
  assign cpu.cpu_rdata = rst_n ? rdata_c : 32'h0;
  assign ram_wstrobe   = ram_we_c & rst_n;

  always_comb begin
    read_mux = '0;
    case (cpu.cpu_addr[3:2])
      REG_LEDS:   read_mux = {leds4, leds3, leds2, leds1};
      REG_KEYS:   read_mux = {28'h0, key_state};
      REG_PRESS:  read_mux = {28'h0, press_flags};
      REG_CYCLES: read_mux = cycle_count;
      default:    read_mux = '0;
    endcase
  end

  // Address and write flag are frozen at decode; the IO write later uses the
  // live cpu_wdata during IO_RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_sel  <= '0;
      wr_q     <= 1'b0;
      io_rdata <= '0;
      leds1    <= '0;
      leds2    <= '0;
      leds3    <= '0;
      leds4    <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (decode_fire) begin
        reg_sel  <= cpu.cpu_addr[3:2];
        wr_q     <= cpu.cpu_wstrobe;
        io_rdata <= read_mux;
      end
      if (state == IO_RESP && wr_q && reg_sel == REG_LEDS) begin
        leds1 <= cpu.cpu_wdata[7:0];
        leds2 <= cpu.cpu_wdata[15:8];
        leds3 <= cpu.cpu_wdata[23:16];
        leds4 <= cpu.cpu_wdata[31:24];
      end
      if ((decode_fire && !hit_ram && !hit_io) || timeout_hit) begin
        bus_err <= 1'b1;
      end
    end
  end

  assign press_clear = (state == IO_RESP && wr_q && reg_sel == REG_PRESS) ?
                       cpu.cpu_wdata[3:0] : 4'h0;

  // Set is OR-ed in after the clear so a simultaneous press wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_flags <= '0;
    end else begin
      press_flags <= (press_flags & ~press_clear) | key_press;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_soc_mmio_bridge.sv
// tb_soc_mmio_bridge
// Directed testbench for soc_mmio_bridge: LED register, keys, press flags,
// RAM routing and handshake, unmapped-address errors, cycle counter, reset
// in the middle of a RAM access and, with SOC_MMIO_TIMEOUT_EN, the RAM timeout.
module tb_soc_mmio_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wstrobe;
  logic [31:0] ram_rdata;
  logic        ram_done;
  logic [3:0]  key_state;
  logic [3:0]  key_press;
  logic [7:0]  leds1, leds2, leds3, leds4;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  soc_mmio_bridge_if bus ();

  soc_mmio_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu         (bus),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_wstrobe (ram_wstrobe),
    .ram_rdata   (ram_rdata),
    .ram_done    (ram_done),
    .key_state   (key_state),
    .key_press   (key_press),
    .leds1       (leds1),
    .leds2       (leds2),
    .leds3       (leds3),
    .leds4       (leds4),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the end of the sequence");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One CPU access, starting at a negedge. The bench also plays the RAM:
  // ram_done is raised in wait cycle ram_lat (0 = never). press_at_done is
  // pulsed on key_press during the completion cycle.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic wr, input int ram_lat,
                                input logic [31:0] ram_data, input logic [3:0] press_at_done,
                                input int budget, output logic [31:0] rdata,
                                output int lat, output logic ws_any, output logic ws_all);
    logic got;
    bus.cpu_valid   = 1'b1;
    bus.cpu_addr    = addr;
    bus.cpu_wdata   = wdata;
    bus.cpu_wstrobe = wr;
    lat    = 0;
    ws_any = 1'b0;
    ws_all = 1'b1;
    rdata  = 32'h0;
    got    = 1'b0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      ram_done  = (ram_lat > 0) && (lat == ram_lat);
      ram_rdata = ram_done ? ram_data : 32'hDEAD_BEEF;
      #1;
      ws_any = ws_any | ram_wstrobe;
      ws_all = ws_all & ram_wstrobe;
      if (bus.cpu_done) begin
        got           = 1'b1;
        rdata         = bus.cpu_rdata;
        bus.cpu_valid = 1'b0;
        key_press     = press_at_done;
      end
    end
    if (!got) begin
      bus.cpu_valid = 1'b0;
      check_output("done_within_budget", 32'd0, 32'd1);
    end
    @(negedge clk);
    ram_done  = 1'b0;
    key_press = 4'h0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rd2;
    int          lat;
    logic        wsa;
    logic        wsl;

    rst_n           = 1'b0;
    bus.cpu_valid   = 1'b0;
    bus.cpu_addr    = 32'h0;
    bus.cpu_wdata   = 32'h0;
    bus.cpu_wstrobe = 1'b0;
    ram_rdata       = 32'h0;
    ram_done        = 1'b0;
    key_state       = 4'h0;
    key_press       = 4'h0;

    repeat (3) @(negedge clk);
    #1;
    check_output("rst_cpu_done", 32'(bus.cpu_done), 32'd0);
    check_output("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check_output("rst_ram_wstrobe", 32'(ram_wstrobe), 32'd0);
    check_output("rst_leds", {leds4, leds3, leds2, leds1}, 32'h0);
    check_output("rst_bus_err", 32'(bus_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] LED register");
    apply_stimulus(32'h8000_0000, 32'hA5C3_0F81, 1'b1, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("led_wr_latency", 32'(lat), 32'd1);
    check_output("leds1", 32'(leds1), 32'h81);
    check_output("leds2", 32'(leds2), 32'h0F);
    check_output("leds3", 32'(leds3), 32'hC3);
    check_output("leds4", 32'(leds4), 32'hA5);
    apply_stimulus(32'h8000_0000, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("led_rd_data", rd, 32'hA5C3_0F81);
    check_output("led_rd_latency", 32'(lat), 32'd1);

    $display("[TB] KEYS register");
    key_state = 4'b1010;
    apply_stimulus(32'h8000_0004, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("keys_rd", rd, 32'h0000_000A);
    apply_stimulus(32'h8000_0004, 32'hFFFF_FFFF, 1'b1, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("keys_wr_ignored", {leds4, leds3, leds2, leds1}, 32'hA5C3_0F81);

    $display("[TB] PRESS register");
    key_press = 4'b0100;
    @(negedge clk);
    key_press = 4'h0;
    apply_stimulus(32'h8000_0008, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("press_set", rd, 32'h4);
    apply_stimulus(32'h8000_0008, 32'h4, 1'b1, 0, 32'h0, 4'b0100, 20, rd, lat, wsa, wsl);
    apply_stimulus(32'h8000_0008, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("press_set_wins", rd, 32'h4);
    apply_stimulus(32'h8000_0008, 32'h4, 1'b1, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    apply_stimulus(32'h8000_0008, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("press_cleared", rd, 32'h0);

    $display("[TB] RAM accesses");
    apply_stimulus(32'h0000_0010, 32'h0, 1'b0, 2, 32'h1234_5678, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("ram_rd_data", rd, 32'h1234_5678);
    check_output("ram_rd_latency", 32'(lat), 32'd2);
    check_output("ram_rd_no_wstrobe", 32'(wsa), 32'd0);
    apply_stimulus(32'h0000_0010, 32'hCAFE_F00D, 1'b1, 3, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("ram_wr_latency", 32'(lat), 32'd3);
    check_output("ram_wr_wstrobe_held", 32'(wsl), 32'd1);
    check_output("ram_wdata_pass", ram_wdata, 32'hCAFE_F00D);
    apply_stimulus(32'h0000_0FFC, 32'h0, 1'b0, 1, 32'h1111_2222, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("ram_top_word", rd, 32'h1111_2222);
    check_output("ram_no_bus_err", 32'(bus_err), 32'd0);

    $display("[TB] unmapped accesses");
    apply_stimulus(32'h4000_0000, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("err_latency", 32'(lat), 32'd1);
    check_output("err_rdata", rd, 32'h0);
    check_output("err_bus_err", 32'(bus_err), 32'd1);
    apply_stimulus(32'h0000_1000, 32'h0, 1'b0, 1, 32'h5555_5555, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("ram_end_is_err_rdata", rd, 32'h0);
    check_output("ram_end_is_err_latency", 32'(lat), 32'd1);
    apply_stimulus(32'h8000_0010, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("io_end_is_err", rd, 32'h0);
    apply_stimulus(32'h8000_0000, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("good_after_err", rd, 32'hA5C3_0F81);
    check_output("bus_err_sticky", 32'(bus_err), 32'd1);

    $display("[TB] CYCLES register");
    apply_stimulus(32'h8000_000C, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    repeat (8) @(negedge clk);
    apply_stimulus(32'h8000_000C, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd2, lat, wsa, wsl);
    check_output("cycles_delta", rd2 - rd, 32'd10);
    force dut.cycle_count = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_count;
    apply_stimulus(32'h8000_000C, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    apply_stimulus(32'h8000_000C, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd2, lat, wsa, wsl);
    check_output("cycles_preload", rd, 32'hFFFF_FFFE);
    check_output("cycles_wrap", rd2, 32'h0);

    $display("[TB] reset during RAM_WAIT");
    bus.cpu_valid   = 1'b1;
    bus.cpu_addr    = 32'h0000_0020;
    bus.cpu_wdata   = 32'h0BAD_0BAD;
    bus.cpu_wstrobe = 1'b1;
    ram_done        = 1'b0;
    @(negedge clk);
    #1;
    check_output("midrst_wstrobe_before", 32'(ram_wstrobe), 32'd1);
    rst_n         = 1'b0;
    ram_done      = 1'b1;
    bus.cpu_valid = 1'b0;
    #1;
    check_output("midrst_no_done", 32'(bus.cpu_done), 32'd0);
    @(negedge clk);
    #1;
    check_output("midrst_wstrobe_after", 32'(ram_wstrobe), 32'd0);
    check_output("midrst_done_after", 32'(bus.cpu_done), 32'd0);
    check_output("midrst_bus_err_clr", 32'(bus_err), 32'd0);
    check_output("midrst_leds_clr", {leds4, leds3, leds2, leds1}, 32'h0);
    ram_done  = 1'b0;
    rst_n     = 1'b1;
    key_press = 4'b0001;
    @(negedge clk);
    key_press = 4'h0;
    apply_stimulus(32'h8000_0008, 32'h0, 1'b0, 0, 32'h0, 4'h0, 20, rd, lat, wsa, wsl);
    check_output("press_after_reset", rd, 32'h1);

`ifdef SOC_MMIO_TIMEOUT_EN
    $display("[TB] RAM timeout");
    apply_stimulus(32'h0000_0030, 32'h0, 1'b0, 0, 32'h0, 4'h0, 300, rd, lat, wsa, wsl);
    check_output("timeout_latency", 32'(lat), 32'd255);
    check_output("timeout_rdata", rd, 32'h0);
    check_output("timeout_bus_err", 32'(bus_err), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
